pio_stream_out: RTL and testbench
=================================

# pio_stream_out

Parametrised Avalon-MM write slave that pushes CPU writes into an on-chip FIFO and drains them as a valid/ready stream toward fabric logic (e.g. the plate-recognition accelerator input). It is the buffered successor of the single-register 128-bit PIO output. It adds configurable width and depth, real burst handling, byte-enable merging, FIFO flush and per-burst write responses. Stalls come from FIFO fullness rather than from an external block signal.

## Interface
- DATA_W, 128: data width in bits; multiple of 8.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- BURST_W, 4: burstcount width; maximum burst is 2^BURST_W−1 beats.
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- avs_s0_address  in  2  word address: 0 = data push, 1 = control, 2/3 = reserved.
- avs_s0_write  in  1  write request.
- avs_s0_writedata  in  DATA_W  write data.
- avs_s0_byteenable  in  DATA_W/8  byte lanes of this beat.
- avs_s0_burstcount  in  BURST_W  beats in the burst; sampled on the first beat only.
- avs_s0_waitrequest  out  1  beat not accepted this cycle.
- avs_s0_response  out  2  00 OKAY, 10 SLVERR; valid with writeresponsevalid.
- avs_s0_writeresponsevalid  out  1  one-cycle pulse per completed burst.
- pio_out  out  DATA_W  FIFO head word.
- pio_valid  out  1  FIFO not empty.
- pio_ready  in  1  consumer accepts head this cycle.
- fill_level  out  $clog2(DEPTH)+1  current entry count.

## Operation
- A beat is accepted when avs_s0_write=1 and avs_s0_waitrequest=0.
- FSM states:
  - IDLE: first accepted beat latches address and burstcount into burst_addr and beats_left=burstcount−1. If beats_left=0, go to RESP; otherwise go to BURST.
  - BURST: each accepted beat decrements beats_left. The beat taking beats_left to 0 moves to RESP. avs_s0_address is ignored; burst_addr applies.
  - RESP: writeresponsevalid=1 for this one cycle, then IDLE. A new first beat in RESP is accepted and handled exactly as in IDLE, so back-to-back bursts lose no cycle.
- burstcount=0 on a first beat is treated as a 1-beat burst with response SLVERR.
- Data beats (address 0):
  - Merge: word = (writedata & mask) | (shadow & ~mask), where mask expands byteenable to bytes.
  - shadow ← word; word is pushed to the FIFO.
  - shadow resets to 0.
- Control beats (address 1): writedata[0]=1 flushes the FIFO, setting count, rd_ptr and wr_ptr to 0 at the next edge. Other bits are ignored. shadow is unchanged.
- Reserved addresses: beats are accepted and discarded; the burst response is SLVERR. Response is OKAY otherwise; SLVERR is sticky within a burst.
- avs_s0_waitrequest = (FIFO full) AND (beat targets address 0), computed combinationally from burst_addr in BURST and from avs_s0_address otherwise. There is no push-through on simultaneous pop while full.
- Pop occurs when pio_valid && pio_ready. pio_out is registered FIFO-head data, valid whenever pio_valid=1.
- Same-cycle push and pop: count is unchanged and both pointers advance.
- Flush in the same cycle as a pop: the flush wins and the pop is lost.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill_level = count, range 0..DEPTH.

## Timing
- Reset values:
  - pio_valid=0, fill_level=0, pio_out=0.
  - writeresponsevalid=0, response=00, waitrequest=0.
  - FSM in IDLE, shadow=0.
- Reset asserted mid-burst aborts the burst. No response is issued, and the FIFO and all state return to reset values.
- Push latency: a beat accepted at edge N gives pio_valid=1 and pio_out=word after edge N (when the FIFO was empty).
- Pop latency: pio_out shows the next entry after the popping edge.
- Response: writeresponsevalid is high for the one cycle following acceptance of the final beat.
- Full→not-full: waitrequest drops in the cycle after the popping edge.

## Test plan
- Single write, DATA_W=128, address 0, burstcount=1, byteenable all-ones, data 0x…DEAD, pio_ready=0 → pio_valid=1 next cycle, pio_out=0x…DEAD, fill_level=1, one response 00 a cycle after acceptance.
- 4-beat burst of values 1..4 with pio_ready=1 → stream emits 1,2,3,4 in order and exactly one writeresponsevalid after beat 4.
- DEPTH=8, pio_ready=0, 10-beat burst → beats 1–8 accepted, waitrequest=1 on beat 9 with fill_level=8. Raising pio_ready for one cycle accepts beat 9 one cycle later; the response comes only after beat 10.
- Byte merge: write 0x1111…11 full-enable, then 0x2222…22 with byteenable=0x0001 → second popped word = 0x1111…1122.
- Control write 0x1 to address 1 with 5 entries queued and pio_ready=1 → fill_level=0 and pio_valid=0 next cycle, response 00.
- Write to address 2, and a separate burstcount=0 write → no FIFO change for address 2, a 1-beat push for burstcount=0, and response 10 for each. Assert reset_n=0 mid-burst → all outputs at reset values, no response pulse.

Source files
------------

// File: rtl/pio_stream_out.sv
// rtl/pio_stream_out.sv - Avalon-MM burst write slave feeding a FIFO drained as a valid/ready stream
module pio_stream_out #(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 8,
    parameter int BURST_W = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 avs_s0_address,
    input  logic                       avs_s0_write,
    input  logic [DATA_W-1:0]          avs_s0_writedata,
    input  logic [DATA_W/8-1:0]        avs_s0_byteenable,
    input  logic [BURST_W-1:0]         avs_s0_burstcount,
    output logic                       avs_s0_waitrequest,
    output logic [1:0]                 avs_s0_response,
    output logic                       avs_s0_writeresponsevalid,
    output logic [DATA_W-1:0]          pio_out,
    output logic                       pio_valid,
    input  logic                       pio_ready,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int AW   = $clog2(DEPTH);
    localparam int BE_W = DATA_W / 8;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           burst_addr_q, burst_addr_d;
    logic [BURST_W-1:0]   beats_left_q, beats_left_d;
    logic                 err_q, err_d;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [AW:0]          count;
    logic [DATA_W-1:0]    shadow;
    logic [DATA_W-1:0]    word;

    logic [1:0]           eff_addr;
    logic                 full, accept, push, pop, flush;

    // Decode the beat target and handshake; later burst beats reuse the latched address
    always_comb begin
        eff_addr           = (state_q == BURST) ? burst_addr_q : avs_s0_address;
        full               = (count == FULL_CNT);
        avs_s0_waitrequest = full && (eff_addr == 2'd0);
        accept             = avs_s0_write && !avs_s0_waitrequest;
        push               = accept && (eff_addr == 2'd0);
        flush              = accept && (eff_addr == 2'd1) && avs_s0_writedata[0];
        pop                = pio_valid && pio_ready;
    end

    // Byte-lane merge of the incoming beat over the last pushed word
    always_comb begin
        word = shadow;
        for (int i = 0; i < BE_W; i++) begin
            if (avs_s0_byteenable[i]) begin
                word[i*8 +: 8] = avs_s0_writedata[i*8 +: 8];
            end
        end
    end

    // Burst tracking: next state, remaining beats and sticky error
    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        beats_left_d = beats_left_q;
        err_d        = err_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    burst_addr_d = avs_s0_address;
                    err_d        = (avs_s0_burstcount == '0) || avs_s0_address[1];
                    if (avs_s0_burstcount <= BURST_W'(1)) begin
                        beats_left_d = '0;
                        state_d      = RESP;
                    end else begin
                        beats_left_d = avs_s0_burstcount - 1'b1;
                        state_d      = BURST;
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == BURST_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            burst_addr_q <= '0;
            beats_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            beats_left_q <= beats_left_d;
            err_q        <= err_d;
        end
    end

    // FIFO storage, pointers and count; flush overrides a same-cycle pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            shadow <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                shadow      <= word;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    // Stream side and write response outputs
    always_comb begin
        pio_out                   = mem[rd_ptr];
        pio_valid                 = (count != '0);
        fill_level                = count;
        avs_s0_writeresponsevalid = (state_q == RESP);
        avs_s0_response           = ((state_q == RESP) && err_q) ? 2'b10 : 2'b00;
    end

endmodule

// File: tb/tb_pio_stream_out.sv
// tb/tb_pio_stream_out.sv - self-checking bench for pio_stream_out with a queue-based reference model
module tb_pio_stream_out;

    localparam int DATA_W  = 128;
    localparam int DEPTH   = 8;
    localparam int BURST_W = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [1:0]         address = '0;
    logic               write = 1'b0;
    logic [DATA_W-1:0]  wdata = '0;
    logic [15:0]        be = '0;
    logic [3:0]         bc = '0;
    logic               waitrequest;
    logic [1:0]         response;
    logic               rvalid;
    logic [DATA_W-1:0]  pio_out;
    logic               pio_valid;
    logic               pio_ready = 1'b0;
    logic [3:0]         fill_level;

    int checks = 0;
    int failures = 0;
    int mode = 0;

    pio_stream_out #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_W(BURST_W)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .avs_s0_address            (address),
        .avs_s0_write              (write),
        .avs_s0_writedata          (wdata),
        .avs_s0_byteenable         (be),
        .avs_s0_burstcount         (bc),
        .avs_s0_waitrequest        (waitrequest),
        .avs_s0_response           (response),
        .avs_s0_writeresponsevalid (rvalid),
        .pio_out                   (pio_out),
        .pio_valid                 (pio_valid),
        .pio_ready                 (pio_ready),
        .fill_level                (fill_level)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_shadow = '0;
    bit                m_in_burst = 0;
    int                m_rem = 0;
    logic [1:0]        m_baddr = '0;
    bit                m_err = 0;
    bit                m_rvalid = 0;
    logic [1:0]        m_resp = '0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_p
        logic [1:0]        tgt;
        bit                acc;
        bit                last;
        logic [DATA_W-1:0] w;
        if (!reset_n) begin
            q.delete();
            m_shadow   = '0;
            m_in_burst = 0;
            m_rem      = 0;
            m_err      = 0;
            m_rvalid   = 0;
            m_resp     = '0;
        end else begin
            tgt  = m_in_burst ? m_baddr : address;
            acc  = write && !((q.size() == DEPTH) && (tgt == 2'd0));
            last = 0;
            if (acc) begin
                if (!m_in_burst) begin
                    m_baddr = address;
                    m_err   = (bc == 0) || (address >= 2);
                    m_rem   = (bc == 0) ? 0 : int'(bc) - 1;
                end else begin
                    m_rem = m_rem - 1;
                end
                last       = (m_rem == 0);
                m_in_burst = !last;
            end
            if (acc && tgt == 2'd1 && wdata[0]) begin
                q.delete();
            end else begin
                if (q.size() > 0 && pio_ready) void'(q.pop_front());
                if (acc && tgt == 2'd0) begin
                    for (int b = 0; b < DATA_W/8; b++)
                        w[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : m_shadow[b*8 +: 8];
                    q.push_back(w);
                    m_shadow = w;
                end
            end
            m_rvalid = last;
            m_resp   = m_err ? 2'b10 : 2'b00;
        end
    end

    always @(negedge clk) begin : compare_p
        logic [1:0] tgt;
        tgt = m_in_burst ? m_baddr : address;
        chk("m_valid", pio_valid, q.size() > 0);
        chk("m_fill", fill_level, q.size());
        if (q.size() > 0) chk("m_data", pio_out, q[0]);
        chk("m_wait", waitrequest, (q.size() == DEPTH) && (tgt == 2'd0));
        chk("m_rvalid", rvalid, m_rvalid);
        if (m_rvalid) chk("m_resp", response, m_resp);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            pio_ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : (mode == 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_beat(input logic [1:0] a, input logic [DATA_W-1:0] d,
                           input logic [15:0] e, input logic [3:0] c);
        bit done;
        done    = 0;
        write   = 1'b1;
        address = a;
        wdata   = d;
        be      = e;
        bc      = c;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!waitrequest) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=stalled required=accepted at %0t", $time);
        end
        @(posedge clk);
        #2;
        write = 1'b0;
    endtask

    task automatic pulse_ready();
        tick();
        mode = 1;
        tick();
        mode = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]        rbc;
        logic [1:0]        ra;
        logic [DATA_W-1:0] rd;
        int                nb;
        int                r;

        repeat (2) tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_fill", fill_level, 0);
        chk("rst_valid", pio_valid, 0);
        chk("rst_out", pio_out, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_resp", response, 0);
        chk("rst_wait", waitrequest, 0);
        tick();

        // single write
        do_beat(2'd0, 128'hDEAD, 16'hFFFF, 4'd1);
        @(negedge clk);
        chk("single_valid", pio_valid, 1);
        chk("single_out", pio_out, 128'hDEAD);
        chk("single_fill", fill_level, 1);
        chk("single_rvalid", rvalid, 1);
        chk("single_resp", response, 2'b00);
        tick();
        do_beat(2'd1, 128'h1, 16'hFFFF, 4'd1);

        // 4-beat burst streamed straight out
        mode = 1;
        for (int i = 1; i <= 4; i++)
            do_beat((i == 1) ? 2'd0 : 2'($urandom_range(0, 3)), DATA_W'(i), 16'hFFFF,
                    (i == 1) ? 4'd4 : 4'($urandom_range(0, 15)));
        repeat (4) tick();
        mode = 0;
        @(negedge clk);
        chk("burst4_drained", fill_level, 0);
        tick();

        // overflow: 10-beat burst into an 8-deep FIFO
        for (int i = 0; i < 8; i++)
            do_beat((i == 0) ? 2'd0 : 2'($urandom_range(0, 3)), DATA_W'(100 + i), 16'hFFFF,
                    (i == 0) ? 4'd10 : 4'd0);
        write   = 1'b1;
        address = 2'd3;
        wdata   = DATA_W'(108);
        @(negedge clk);
        chk("ovf_wait", waitrequest, 1);
        chk("ovf_fill", fill_level, 8);
        pulse_ready();
        chk("ovf_wait_drop", waitrequest, 0);
        chk("ovf_fill_pop", fill_level, 7);
        @(posedge clk);
        #2;
        wdata = DATA_W'(109);
        mode  = 1;
        @(negedge clk);
        chk("ovf_no_early_resp", rvalid, 0);
        chk("ovf_refill", fill_level, 8);
        tick();
        do_beat(2'd2, DATA_W'(109), 16'hFFFF, 4'd0);
        @(negedge clk);
        chk("ovf_resp_valid", rvalid, 1);
        chk("ovf_resp", response, 2'b00);
        repeat (12) tick();
        mode = 0;

        // byte merge
        do_beat(2'd0, {16{8'h11}}, 16'hFFFF, 4'd1);
        do_beat(2'd0, {16{8'h22}}, 16'h0001, 4'd1);
        @(negedge clk);
        chk("merge_fill", fill_level, 2);
        pulse_ready();
        chk("merge_word", pio_out, 128'h11111111111111111111111111111122);
        chk("merge_fill_pop", fill_level, 1);
        tick();

        // flush with entries queued
        for (int i = 0; i < 4; i++) do_beat(2'd0, DATA_W'(200 + i), 16'hFFFF, 4'd1);
        @(negedge clk);
        chk("flush_pre_fill", fill_level, 5);
        tick();
        mode = 1;
        do_beat(2'd1, 128'h1, 16'hFFFF, 4'd1);
        @(negedge clk);
        chk("flush_fill", fill_level, 0);
        chk("flush_valid", pio_valid, 0);
        chk("flush_rvalid", rvalid, 1);
        chk("flush_resp", response, 2'b00);
        tick();
        mode = 0;

        // reserved address and burstcount zero
        do_beat(2'd0, 128'hA5, 16'hFFFF, 4'd1);
        do_beat(2'd2, 128'h5A, 16'hFFFF, 4'd1);
        @(negedge clk);
        chk("rsvd_fill", fill_level, 1);
        chk("rsvd_rvalid", rvalid, 1);
        chk("rsvd_resp", response, 2'b10);
        tick();
        do_beat(2'd0, 128'h77, 16'hFFFF, 4'd0);
        @(negedge clk);
        chk("bc0_fill", fill_level, 2);
        chk("bc0_rvalid", rvalid, 1);
        chk("bc0_resp", response, 2'b10);
        tick();

        // reset in the middle of a burst
        do_beat(2'd0, 128'h1, 16'hFFFF, 4'd5);
        do_beat(2'd0, 128'h2, 16'hFFFF, 4'd0);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("mrst_fill", fill_level, 0);
        chk("mrst_valid", pio_valid, 0);
        chk("mrst_out", pio_out, 0);
        chk("mrst_rvalid", rvalid, 0);
        chk("mrst_wait", waitrequest, 0);
        tick();

        // randomized traffic
        mode = 2;
        repeat (300) begin
            rbc = 4'($urandom_range(0, 7));
            nb  = (rbc == 0) ? 1 : int'(rbc);
            r   = $urandom_range(0, 99);
            ra  = (r < 75) ? 2'd0 : (r < 85) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
            for (int j = 0; j < nb; j++) begin
                rd = {$urandom, $urandom, $urandom, $urandom};
                if (ra == 2'd1) rd[0] = ($urandom_range(0, 3) == 0);
                do_beat((j == 0) ? ra : 2'($urandom_range(0, 3)), rd, 16'($urandom),
                        (j == 0) ? rbc : 4'($urandom_range(0, 15)));
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        mode = 1;
        repeat (20) tick();
        @(negedge clk);
        chk("final_drained", fill_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
